regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter_if.sv | 32 +++
 rtl/regfile_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Requester/arbiter bus for the shared register-file write port.
// Carries the packed request vectors, the grant handshake and the registered write outputs.
interface regfile_wr_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
);
  localparam int unsigned NRF = 1 << AW;
  localparam int unsigned CW  = 16;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               stall;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [NRF-1:0]     rf_we_onehot;
  logic [CW-1:0]      conflict_cnt;

  // Requester side: presents writes, observes grants and the bank write port.
  modport master (
    output req_valid, req_addr, req_data, stall,
    input  req_ready, rf_we, rf_waddr, rf_wdata, rf_we_onehot, conflict_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, stall,
    output req_ready, rf_we, rf_waddr, rf_wdata, rf_we_onehot, conflict_cnt
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters.
// Grant is combinational; the bank write port and the contention counter are registered.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NRF = 1 << AW;
  localparam int unsigned CW  = 16;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  gnt_idx;
  logic [PW-1:0]  cand;
  logic           gnt_found;
  logic           xfer;
  logic           multi;
  logic [NREQ-1:0] ready_c;
  logic [AW-1:0]  win_addr;
  logic [DW-1:0]  win_data;

  logic           rf_we_q, rf_we_d;
  logic [AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]  rf_wdata_q, rf_wdata_d;
  logic [NRF-1:0] rf_we_onehot_q, rf_we_onehot_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin : grant_search
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (32'(ptr_q) + k >= NREQ) begin
        cand = PW'(32'(ptr_q) + k - NREQ);
      end else begin
        cand = PW'(32'(ptr_q) + k);
      end
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin : winner_mux
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == gnt_idx) begin
        win_addr = bus.req_addr[i*AW +: AW];
        win_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin : handshake
    xfer    = gnt_found && !bus.stall && !rst;
    multi   = ($countones(bus.req_valid) > 1);
    ready_c = '0;
    if (xfer) begin
      ready_c[gnt_idx] = 1'b1;
    end
  end

  always_comb begin : next_state
    ptr_d          = ptr_q;
    rf_we_d        = 1'b0;
    rf_we_onehot_d = '0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    cnt_d          = cnt_q;
    if (xfer) begin
      ptr_d      = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
      // x0 is hardwired zero: complete the handshake but suppress the strobe.
      if (win_addr != '0) begin
        rf_we_d        = 1'b1;
        rf_we_onehot_d = NRF'(1) << win_addr;
      end
    end
    if (multi && !bus.stall && cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      ptr_q          <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      rf_we_onehot_q <= '0;
      cnt_q          <= '0;
    end else begin
      ptr_q          <= ptr_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      rf_we_onehot_q <= rf_we_onehot_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.req_ready    = ready_c;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.rf_we_onehot = rf_we_onehot_q;
  assign bus.conflict_cnt = cnt_q;

  // Structural invariants of the grant and the decoded enables.
  a_ready_onehot: assert property (@(posedge clk) $onehot0(ready_c));
  a_we_onehot: assert property (@(posedge clk)
    $onehot0(rf_we_onehot_q) && ((rf_we_onehot_q != '0) == rf_we_q));
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a spec-level reference model.
module tb_regfile_wr_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NRF  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  int              m_ptr;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [NRF-1:0]  m_oh;
  int              m_cnt;
  logic [NREQ-1:0] last_ready;
  int              last_g;
  int              order_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check grant before the edge, advance the model, check registered outputs after.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    logic [AW-1:0]   a;
    int g;
    @(negedge clk);
    g = pick(bus.req_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0 && !rst && !bus.stall) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    last_ready = bus.req_ready;
    last_g = (exp_rdy != '0) ? g : -1;
    if (rst) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_oh = '0; m_cnt = 0;
    end else begin
      m_we = 1'b0;
      m_oh = '0;
      if (last_g >= 0) begin
        a      = bus.req_addr[g*AW +: AW];
        m_addr = a;
        m_data = bus.req_data[g*DW +: DW];
        if (a != '0) begin
          m_we = 1'b1;
          m_oh = NRF'(1) << a;
        end
        m_ptr = (g + 1) % NREQ;
      end
      if ($countones(bus.req_valid) >= 2 && !bus.stall && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
    chk("rf_we", 64'(bus.rf_we), 64'(m_we));
    chk("rf_waddr", 64'(bus.rf_waddr), 64'(m_addr));
    chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_data));
    chk("rf_we_onehot", 64'(bus.rf_we_onehot), 64'(m_oh));
    chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
  endtask

  // New request only where the previous one was accepted or none was pending.
  task automatic rand_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req_valid[i] || last_g == i) begin
        bus.req_valid[i] = ($urandom_range(0, 9) < 6);
        bus.req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, NRF-1));
        bus.req_data[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  initial begin
    int saved_cnt;
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_oh = '0; m_cnt = 0;
    last_g = -1;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));

    // Reset held two cycles with all requesters valid.
    repeat (2) begin
      tick();
      chk("reset_ready", 64'(last_ready), 64'h0);
    end
    rst = 1'b0;
    bus.req_valid = '0;
    tick();
    chk("reset_we", 64'(bus.rf_we), 64'h0);
    chk("reset_oh", 64'(bus.rf_we_onehot), 64'h0);
    chk("reset_cnt", 64'(bus.conflict_cnt), 64'h0);

    // Single write from requester 1.
    bus.req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("sw_ready", 64'(last_ready), 64'h2);
    chk("sw_we", 64'(bus.rf_we), 64'h1);
    chk("sw_waddr", 64'(bus.rf_waddr), 64'h5);
    chk("sw_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
    chk("sw_oh", 64'(bus.rf_we_onehot), 64'h20);
    bus.req_valid = '0;
    tick();
    chk("sw_we_off", 64'(bus.rf_we), 64'h0);

    // Round-robin from reset: each requester drops valid after its grant for one cycle.
    rst = 1'b1;
    bus.req_valid = 3'b111;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 3), DW'(32'h100 + i));
    repeat (6) begin
      tick();
      order_q.push_back(last_g);
      bus.req_valid = 3'b111;
      if (last_g >= 0) bus.req_valid[last_g] = 1'b0;
    end
    for (int i = 0; i < 6; i++) chk("rr_order", 64'(order_q[i]), 64'(i % 3));
    chk("rr_cnt", 64'(bus.conflict_cnt), 64'd6);

    // x0 write must still advance the pointer (ptr=2 before it).
    bus.req_valid = 3'b010;
    tick();
    bus.req_valid = 3'b100;
    set_req(2, 5'd0, 32'h1234);
    tick();
    chk("x0_ready", 64'(last_ready), 64'h4);
    chk("x0_we", 64'(bus.rf_we), 64'h0);
    chk("x0_oh", 64'(bus.rf_we_onehot), 64'h0);
    bus.req_valid = 3'b101;
    set_req(2, 5'd9, 32'h5678);
    tick();
    chk("x0_next_grant", 64'(last_ready), 64'h1);

    // Stall with ptr=1 and requesters 1 and 2 pending.
    bus.req_valid = 3'b110;
    bus.stall = 1'b1;
    saved_cnt = m_cnt;
    repeat (3) begin
      tick();
      chk("stall_ready", 64'(last_ready), 64'h0);
      chk("stall_we", 64'(bus.rf_we), 64'h0);
      chk("stall_cnt", 64'(bus.conflict_cnt), 64'(saved_cnt));
    end
    bus.stall = 1'b0;
    tick();
    chk("stall_release", 64'(last_ready), 64'h2);

    // Randomized traffic with occasional stall and reset.
    bus.req_valid = '0;
    last_g = -1;
    for (int n = 0; n < 1500; n++) begin
      rand_reqs();
      bus.stall = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;
    bus.stall = 1'b0;

    // Counter saturation under continuous dual requests.
    bus.req_valid = 3'b011;
    set_req(0, 5'd7, 32'hCAFE0000);
    set_req(1, 5'd31, 32'hCAFE0001);
    repeat (65540) tick();
    chk("sat_cnt", 64'(bus.conflict_cnt), 64'hFFFF);
    repeat (3) tick();
    chk("sat_hold", 64'(bus.conflict_cnt), 64'hFFFF);

    // Reset during a transfer discards it and clears pointer and counter.
    rst = 1'b1;
    tick();
    chk("midrst_ready", 64'(last_ready), 64'h0);
    chk("midrst_we", 64'(bus.rf_we), 64'h0);
    chk("midrst_cnt", 64'(bus.conflict_cnt), 64'h0);
    rst = 1'b0;
    bus.req_valid = 3'b111;
    tick();
    chk("midrst_ptr", 64'(last_ready), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
